// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: reset vector, FSM encodings and bus size code.
package if_fetch_pkg;

   localparam logic [31:0] IF_RESET_PC = 32'hbfc00000;
   localparam logic [1:0]  SIZE_WORD   = 2'b10;

   typedef enum logic [2:0] {
      IF_S_INIT = 3'd0,
      IF_S_REQ  = 3'd1,
      IF_S_WAIT = 3'd2,
      IF_S_HOLD = 3'd3,
      IF_S_DROP = 3'd4
   } if_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC priority mux (exception > pending branch > sequential) and the AdEF alignment check.
module if_next_pc (
   input  logic [31:0] pc,
   input  logic        exc_redirect,
   input  logic [31:0] exc_target,
   input  logic        br_pend,
   input  logic [31:0] br_pc,
   output logic [31:0] next_pc,
   output logic        adef
);

   always_comb begin
      if (exc_redirect) begin
         next_pc = exc_target;
      end else if (br_pend) begin
         next_pc = br_pc;
      end else begin
         next_pc = pc + 32'd4;
      end
   end

   assign adef = (pc[1:0] != 2'b00);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the SRAM-like fetch handshake and presents one slot to IF/ID.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        ID_stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_redirect,
   input  logic [31:0] exc_target,
   output logic [31:0] IF_out_PC,
   output logic [31:0] IF_inst,
   output logic        IF_AdEF_exception,
   output logic [31:0] IF_bad_inst,
   output logic        IF_stall
);

   if_state_e   state, state_nxt;
   logic [31:0] pc, br_pc, redir_pc, inst_buf, next_pc;
   logic        br_pend, cancel, adef;
   logic        in_req, req_live, slot_valid, consume;

   if_next_pc u_next_pc (
      .pc           (pc),
      .exc_redirect (exc_redirect),
      .exc_target   (exc_target),
      .br_pend      (br_pend),
      .br_pc        (br_pc),
      .next_pc      (next_pc),
      .adef         (adef)
   );

   assign in_req     = (state == IF_S_REQ);
   assign req_live   = in_req & ~adef;
   assign slot_valid = (in_req & adef)
                     | ((state == IF_S_WAIT) & inst_data_ok)
                     | (state == IF_S_HOLD);
   assign consume    = slot_valid & ~ID_stall & ~exc_redirect;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IF_S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IF_S_INIT: state_nxt = IF_S_REQ;
         // An accepted request cannot be withdrawn, so a pending flush drains it through DROP.
         IF_S_REQ: begin
            if (req_live & inst_addr_ok) begin
               state_nxt = (cancel | exc_redirect) ? IF_S_DROP : IF_S_WAIT;
            end
         end
         IF_S_WAIT: begin
            if (inst_data_ok) begin
               if (exc_redirect)  state_nxt = IF_S_REQ;
               else if (ID_stall) state_nxt = IF_S_HOLD;
               else               state_nxt = IF_S_REQ;
            end else if (exc_redirect) begin
               state_nxt = IF_S_DROP;
            end
         end
         IF_S_HOLD: begin
            if (exc_redirect | ~ID_stall) state_nxt = IF_S_REQ;
         end
         IF_S_DROP: begin
            if (inst_data_ok) state_nxt = IF_S_REQ;
         end
         default: state_nxt = IF_S_INIT;
      endcase
   end

   always_comb begin
      inst_req          = req_live;
      IF_stall          = ~slot_valid;
      IF_AdEF_exception = in_req & adef;
      IF_inst           = 32'd0;
      if (state == IF_S_HOLD) begin
         IF_inst = inst_buf;
      end else if ((state == IF_S_WAIT) & inst_data_ok) begin
         IF_inst = inst_rdata;
      end
   end

   assign inst_wr     = 1'b0;
   assign inst_size   = SIZE_WORD;
   assign inst_wdata  = 32'd0;
   assign inst_addr   = pc;
   assign IF_out_PC   = pc;
   assign IF_bad_inst = pc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc       <= RESET_PC;
         br_pend  <= 1'b0;
         br_pc    <= 32'd0;
         cancel   <= 1'b0;
         inst_buf <= 32'd0;
         redir_pc <= 32'd0;
      end else begin
         if ((slot_valid & exc_redirect) | consume) begin
            pc <= next_pc;
         end else if ((state == IF_S_DROP) & inst_data_ok) begin
            pc <= exc_redirect ? exc_target : redir_pc;
         end

         // The redirect target is parked while the old request or response is still in flight.
         if (exc_redirect & ~slot_valid & (state != IF_S_INIT)) begin
            redir_pc <= exc_target;
         end

         if (req_live & inst_addr_ok) begin
            cancel <= 1'b0;
         end else if (req_live & exc_redirect) begin
            cancel <= 1'b1;
         end

         if (exc_redirect) begin
            br_pend <= 1'b0;
         end else if (br_taken & ~ID_stall) begin
            br_pend <= 1'b1;
            br_pc   <= br_target;
         end else if (consume) begin
            br_pend <= 1'b0;
         end

         if ((state == IF_S_WAIT) & inst_data_ok & ID_stall & ~exc_redirect) begin
            inst_buf <= inst_rdata;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: bus responder, downstream consumer and a program-order reference model.
module tb_if_fetch;

   localparam logic [31:0] RPC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        ID_stall, br_taken, exc_redirect;
   logic [31:0] br_target, exc_target;
   logic [31:0] IF_out_PC, IF_inst, IF_bad_inst;
   logic        IF_AdEF_exception, IF_stall;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RPC)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_req          (inst_req),
      .inst_wr           (inst_wr),
      .inst_size         (inst_size),
      .inst_addr         (inst_addr),
      .inst_wdata        (inst_wdata),
      .inst_addr_ok      (inst_addr_ok),
      .inst_data_ok      (inst_data_ok),
      .inst_rdata        (inst_rdata),
      .ID_stall          (ID_stall),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .exc_redirect      (exc_redirect),
      .exc_target        (exc_target),
      .IF_out_PC         (IF_out_PC),
      .IF_inst           (IF_inst),
      .IF_AdEF_exception (IF_AdEF_exception),
      .IF_bad_inst       (IF_bad_inst),
      .IF_stall          (IF_stall)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h0badf00d;
   endfunction

   // reference model: the program-order PC of the next slot to be delivered
   logic [31:0] exp_pc, m_target;
   logic        m_pend;
   // bus responder
   logic        outstanding;
   logic [31:0] out_addr;
   int          lat_cnt;
   logic        prev_req, prev_ack;
   logic [31:0] prev_addr;
   logic [31:0] acc[$];
   int          idle, consumed;
   int          p_ack, max_lat, p_stall, p_br, p_exc, p_unal;

   task automatic clear_inputs();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      ID_stall     = 1'b0;
      br_taken     = 1'b0;
      br_target    = 32'd0;
      exc_redirect = 1'b0;
      exc_target   = 32'd0;
   endtask

   task automatic reset_phase();
      @(negedge clk);
      resetn = 1'b0;
      clear_inputs();
      #1;
      check("rst_req",      32'(inst_req), 32'd0);
      check("rst_addr",     inst_addr, RPC);
      check("rst_stall",    32'(IF_stall), 32'd1);
      check("rst_adef",     32'(IF_AdEF_exception), 32'd0);
      check("rst_inst",     IF_inst, 32'd0);
      check("rst_out_pc",   IF_out_PC, RPC);
      check("rst_bad_inst", IF_bad_inst, RPC);
      check("tie_wr",       32'(inst_wr), 32'd0);
      check("tie_size",     32'(inst_size), 32'd2);
      check("tie_wdata",    inst_wdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn      = 1'b1;
      exp_pc      = RPC;
      m_pend      = 1'b0;
      m_target    = 32'd0;
      outstanding = 1'b0;
      lat_cnt     = 0;
      prev_req    = 1'b0;
      prev_ack    = 1'b0;
      prev_addr   = 32'd0;
      idle        = 0;
   endtask

   task automatic step();
      logic cons;
      @(negedge clk);
      clear_inputs();
      inst_rdata = $urandom;
      if (outstanding && lat_cnt == 0) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem_word(out_addr);
      end
      if (inst_req && !outstanding && ($urandom % 100) < p_ack) inst_addr_ok = 1'b1;
      ID_stall     = (($urandom % 100) < p_stall);
      exc_redirect = (($urandom % 100) < p_exc);
      exc_target   = {16'hbfc0, 14'($urandom), 2'b00};
      if (($urandom % 100) < p_unal) exc_target[1:0] = 2'($urandom_range(1, 3));
      br_target    = $urandom;
      if (!ID_stall && !exc_redirect && !m_pend && ($urandom % 100) < p_br) begin
         br_taken  = 1'b1;
         br_target = {16'hbfc1, 14'($urandom), 2'b00};
      end
      #1;
      if (inst_req) begin
         check("req_aligned", 32'(inst_addr[1:0]), 32'd0);
         check("one_outstanding", 32'(outstanding), 32'd0);
      end
      if (inst_req && prev_req && !prev_ack) check("addr_stable", inst_addr, prev_addr);
      if (!IF_stall) begin
         check("slot_pc",      IF_out_PC, exp_pc);
         check("slot_bad",     IF_bad_inst, exp_pc);
         check("slot_adef",    32'(IF_AdEF_exception), 32'(exp_pc[1:0] != 2'b00));
         check("slot_inst",    IF_inst, (exp_pc[1:0] != 2'b00) ? 32'd0 : mem_word(exp_pc));
         check("slot_no_req",  32'(inst_req), 32'd0);
         idle = 0;
      end else begin
         check("stall_no_adef", 32'(IF_AdEF_exception), 32'd0);
         idle++;
         if (idle > 200) begin
            check("watchdog_idle", 32'(idle), 32'd0);
            idle = 0;
         end
      end
      cons = !IF_stall && !ID_stall && !exc_redirect;
      if (inst_addr_ok && inst_req) begin
         outstanding = 1'b1;
         out_addr    = inst_addr;
         lat_cnt     = $urandom_range(0, max_lat);
         acc.push_back(inst_addr);
      end else if (outstanding) begin
         if (lat_cnt == 0) outstanding = 1'b0;
         else lat_cnt--;
      end
      prev_req  = inst_req;
      prev_ack  = inst_addr_ok;
      prev_addr = inst_addr;
      if (exc_redirect) begin
         exp_pc = exc_target;
         m_pend = 1'b0;
      end else begin
         if (cons) begin
            exp_pc = m_pend ? m_target : exp_pc + 32'd4;
            m_pend = 1'b0;
            consumed++;
         end
         if (br_taken) begin
            m_pend   = 1'b1;
            m_target = br_target;
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      clear_inputs();
      consumed = 0;
      p_ack = 100; max_lat = 0; p_stall = 0; p_br = 0; p_exc = 0; p_unal = 0;
      reset_phase();
      for (int c = 0; c < 10; c++) begin
         step();
         if (c < 6) check("stream_stall", 32'(IF_stall), (c % 2 == 0) ? 32'd1 : 32'd0);
      end
      check("stream_accepts", 32'(acc.size() >= 3), 32'd1);
      if (acc.size() >= 3) begin
         check("stream_addr0", acc[0], 32'hbfc00000);
         check("stream_addr1", acc[1], 32'hbfc00004);
         check("stream_addr2", acc[2], 32'hbfc00008);
      end
      p_ack = 60; max_lat = 3; p_stall = 30; p_br = 10; p_exc = 4; p_unal = 15;
      for (int c = 0; c < 1500; c++) step();
      reset_phase();
      for (int c = 0; c < 1500; c++) step();
      check("progress", 32'(consumed >= 100), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
